// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: basic word type and
// the RV immediate-format / opcode definitions.
package common;
   typedef logic [31:0] u32;
endpackage

package pipes;
   // SH also covers the 5-bit word-shift form; the opcode picks the shamt width.
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_SH   = 3'd6,
      IMM_Z    = 3'd7
   } imm_fmt_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_OP_32  = 7'b0111011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/imm_gen_stage_imm_extract.sv
// Combinational opcode classifier and immediate extractor (module imm_extract).
// IMMGEN_ILLEGAL_EN adds the illegal_c flag for unknown opcodes.
module imm_extract
   import pipes::*;
   import common::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  u32               instr,
   output imm_fmt_t         fmt_c,
   output logic [XLEN-1:0]  imm_c
`ifdef IMMGEN_ILLEGAL_EN
   ,
   output logic             illegal_c
`endif
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       sh_narrow;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   // Format classification from opcode/funct3 only
   always_comb begin
      fmt_c     = IMM_NONE;
      sh_narrow = 1'b0;
`ifdef IMMGEN_ILLEGAL_EN
      illegal_c = 1'b0;
`endif
      case (opcode)
         OP_LOAD, OP_JALR:  fmt_c = IMM_I;
         OP_IMM:            fmt_c = (funct3[1:0] == 2'b01) ? IMM_SH : IMM_I;
         OP_IMM_32: begin
            if (XLEN == 64) begin
               fmt_c     = (funct3[1:0] == 2'b01) ? IMM_SH : IMM_I;
               sh_narrow = 1'b1;
            end else begin
`ifdef IMMGEN_ILLEGAL_EN
               illegal_c = 1'b1;
`endif
            end
         end
         OP_STORE:          fmt_c = IMM_S;
         OP_BRANCH:         fmt_c = IMM_B;
         OP_LUI, OP_AUIPC:  fmt_c = IMM_U;
         OP_JAL:            fmt_c = IMM_J;
         OP_SYSTEM:         fmt_c = funct3[2] ? IMM_Z : IMM_NONE;
         OP_OP:             fmt_c = IMM_NONE;
         OP_OP_32: begin
`ifdef IMMGEN_ILLEGAL_EN
            if (XLEN != 64) illegal_c = 1'b1;
`endif
         end
         default: begin
`ifdef IMMGEN_ILLEGAL_EN
            illegal_c = 1'b1;
`endif
         end
      endcase
   end

   // Immediate assembly; sign source is always instr[31]
   always_comb begin
      imm_c = '0;
      case (fmt_c)
         IMM_I:  imm_c = XLEN'($signed(instr[31:20]));
         IMM_S:  imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:  imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         IMM_U:  imm_c = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_J:  imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         IMM_SH: imm_c = (sh_narrow || XLEN == 32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
         IMM_Z:  imm_c = XLEN'(instr[19:15]);
         default: imm_c = '0;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a one-entry skid buffer.
// Define IMMGEN_ILLEGAL_EN to add the out_illegal port.
module imm_gen_stage
   import pipes::*;
   import common::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  u32               in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output u32               out_instr,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output imm_fmt_t         out_fmt
`ifdef IMMGEN_ILLEGAL_EN
   ,
   output logic             out_illegal
`endif
);

   imm_fmt_t          ext_fmt;
   logic [XLEN-1:0]   ext_imm;
   logic              skid_valid;
   u32                skid_instr;
   logic [XLEN-1:0]   skid_pc;
   logic [XLEN-1:0]   skid_imm;
   imm_fmt_t          skid_fmt;
   logic              accept;
   logic              drain;
   logic              main_from_skid;
   logic              main_from_in;
   logic              skid_from_in;
`ifdef IMMGEN_ILLEGAL_EN
   logic              ext_illegal;
   logic              skid_illegal;
`endif

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr     (in_instr),
      .fmt_c     (ext_fmt),
      .imm_c     (ext_imm)
`ifdef IMMGEN_ILLEGAL_EN
      ,
      .illegal_c (ext_illegal)
`endif
   );

   // Steering: skid refills main first; in_ready is low whenever skid is full
   always_comb begin
      accept         = in_valid && in_ready;
      drain          = out_valid && out_ready;
      main_from_skid = 1'b0;
      main_from_in   = 1'b0;
      skid_from_in   = 1'b0;
      if (drain && skid_valid) begin
         main_from_skid = 1'b1;
      end else if (accept) begin
         if (!out_valid || drain) main_from_in = 1'b1;
         else                     skid_from_in = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_pc       <= '0;
         out_imm      <= '0;
         out_fmt      <= IMM_NONE;
         skid_valid   <= 1'b0;
         skid_instr   <= '0;
         skid_pc      <= '0;
         skid_imm     <= '0;
         skid_fmt     <= IMM_NONE;
         in_ready     <= 1'b1;
`ifdef IMMGEN_ILLEGAL_EN
         out_illegal  <= 1'b0;
         skid_illegal <= 1'b0;
`endif
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (main_from_skid) begin
         out_valid   <= 1'b1;
         out_instr   <= skid_instr;
         out_pc      <= skid_pc;
         out_imm     <= skid_imm;
         out_fmt     <= skid_fmt;
         skid_valid  <= 1'b0;
         in_ready    <= 1'b1;
`ifdef IMMGEN_ILLEGAL_EN
         out_illegal <= skid_illegal;
`endif
      end else if (main_from_in) begin
         out_valid   <= 1'b1;
         out_instr   <= in_instr;
         out_pc      <= in_pc;
         out_imm     <= ext_imm;
         out_fmt     <= ext_fmt;
`ifdef IMMGEN_ILLEGAL_EN
         out_illegal <= ext_illegal;
`endif
      end else if (skid_from_in) begin
         skid_valid   <= 1'b1;
         skid_instr   <= in_instr;
         skid_pc      <= in_pc;
         skid_imm     <= ext_imm;
         skid_fmt     <= ext_fmt;
         in_ready     <= 1'b0;
`ifdef IMMGEN_ILLEGAL_EN
         skid_illegal <= ext_illegal;
`endif
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage (XLEN=64 main instance, XLEN=32 side instance).
// Honours IMMGEN_ILLEGAL_EN when defined.
module tb_imm_gen_stage;
   import pipes::*;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready, out_ready32;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic        in_ready, out_valid;
   logic [31:0] out_instr;
   logic [63:0] out_pc, out_imm;
   imm_fmt_t    out_fmt;
   logic        in_ready32, out_valid32;
   logic [31:0] out_instr32, out_pc32, out_imm32;
   imm_fmt_t    out_fmt32;
`ifdef IMMGEN_ILLEGAL_EN
   logic        out_illegal, out_illegal32;
`endif

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt)
`ifdef IMMGEN_ILLEGAL_EN
      , .out_illegal(out_illegal)
`endif
   );

   imm_gen_stage #(.XLEN(32)) dut32 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_instr(out_instr32),
      .out_pc(out_pc32), .out_imm(out_imm32), .out_fmt(out_fmt32)
`ifdef IMMGEN_ILLEGAL_EN
      , .out_illegal(out_illegal32)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offer one instruction; push its expected result when the handshake completes
   task automatic send(input logic [31:0] instr, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
      int tries = 0;
      exp_t e;
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      while (!in_ready && tries < 50) begin
         @(posedge clk); #1;
         tries++;
      end
      if (!in_ready) begin
         chk("send_timeout", 64'(in_ready), 64'd1);
      end else begin
         e.instr = instr; e.pc = pc; e.imm = imm; e.fmt = fmt; e.ill = ill;
         exp_q.push_back(e);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Monitor: compare every drained entry against the head of the queue
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_instr", 64'(out_instr), 64'(e.instr));
            chk("out_pc", out_pc, e.pc);
            chk("out_imm", out_imm, e.imm);
            chk("out_fmt", 64'(out_fmt), 64'(e.fmt));
`ifdef IMMGEN_ILLEGAL_EN
            chk("out_illegal", 64'(out_illegal), 64'(e.ill));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; out_ready32 = 1'b1;
      in_instr = '0; in_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_imm", out_imm, 64'd0);
      chk("rst_out_fmt", 64'(out_fmt), 64'(IMM_NONE));
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
`ifdef IMMGEN_ILLEGAL_EN
      chk("rst_out_illegal", 64'(out_illegal), 64'd0);
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed formats, full throughput
      send(32'hFFF00093, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0); // addi -1
      send(32'hFE112E23, 64'h1004, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0); // sw -4
      send(32'hFE000CE3, 64'h1008, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0); // beq -8
      send(32'h800000B7, 64'h100C, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0); // lui
      chk("x32_lui_valid", 64'(out_valid32), 64'd1);
      chk("x32_lui_imm", 64'(out_imm32), 64'h0000_0000_8000_0000);
      send(32'h03F09093, 64'h1010, 64'd63, 3'd6, 1'b0);                  // slli 63
      send(32'h4280D093, 64'h1014, 64'd40, 3'd6, 1'b0);                  // srai 40
      send(32'h0080006F, 64'h1018, 64'd8, 3'd5, 1'b0);                   // jal +8
      send(32'h3002D073, 64'h101C, 64'd5, 3'd7, 1'b0);                   // csrrwi zimm 5
      send(32'h003100B3, 64'h1020, 64'd0, 3'd0, 1'b0);                   // add
      send(32'hFFF0809B, 64'h1024, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0); // addiw -1
      send(32'h01F0909B, 64'h1028, 64'd31, 3'd6, 1'b0);                  // slliw 31
      send(32'h00000000, 64'h102C, 64'd0, 3'd0, 1'b1);                   // unknown opcode
      send(32'hFFF00093, 64'h1030, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0); // addi after illegal
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: two absorbed, third waits, all drain in order
      out_ready = 1'b0;
      send(32'h00100093, 64'h2000, 64'd1, 3'd1, 1'b0);
      send(32'h00200093, 64'h2004, 64'd2, 3'd1, 1'b0);
      fork
         send(32'h00300093, 64'h2008, 64'd3, 3'd1, 1'b0);
         begin
            chk("stall_in_ready_low", 64'(in_ready), 64'd0);
            repeat (2) begin @(posedge clk); #1; end
            chk("stall_in_ready_held", 64'(in_ready), 64'd0);
            chk("stall_out_instr_held", 64'(out_instr), 64'h0010_0093);
            out_ready = 1'b1;
            repeat (3) begin
               chk("drain_no_gap", 64'(out_valid), 64'd1);
               @(posedge clk); #1;
            end
            chk("drain_in_ready", 64'(in_ready), 64'd1);
            chk("drain_empty", 64'(out_valid), 64'd0);
         end
      join

      // Flush with both entries full and a same-cycle offer
      out_ready = 1'b0;
      send(32'h00400093, 64'h3000, 64'd4, 3'd1, 1'b0);
      send(32'h00500093, 64'h3004, 64'd5, 3'd1, 1'b0);
      in_valid = 1'b1; in_instr = 32'h00600093; in_pc = 64'h3008; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("flush_no_capture", 64'(out_valid), 64'd0);

      // Reset mid-stream discards held entries
      out_ready = 1'b0;
      send(32'h00700093, 64'h4000, 64'd7, 3'd1, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_imm", out_imm, 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      send(32'hFE112E23, 64'h5000, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
